// File: rtl/gost_block_loader_if.sv
// Byte-stream and block handoff bundle between the host link, the GOST
// loader and the downstream decrypt stage.
interface gost_block_loader_if;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_ready;
   logic [256:1] key;
   logic [64:1]  ciphertext;
   logic         key_loaded;
   logic         blk_valid;
   logic         blk_ready;
   logic         err;

   modport master (
      output in_data, in_valid, blk_ready,
      input  in_ready, key, ciphertext, key_loaded, blk_valid, err
   );

   modport slave (
      input  in_data, in_valid, blk_ready,
      output in_ready, key, ciphertext, key_loaded, blk_valid, err
   );
endinterface

// File: rtl/gost_block_loader.sv
// Command-framed byte loader: assembles a 256-bit key and 64-bit ciphertext
// blocks for the GOST decrypt stage, publishing each only when complete.
module gost_block_loader #(
   parameter logic [7:0] CMD_KEY  = 8'h4B,
   parameter logic [7:0] CMD_DATA = 8'h43
) (
   input logic               clk,
   input logic               rst_n,
   gost_block_loader_if.slave bus
);

   typedef enum logic [1:0] {IDLE, KEY, DATA, HOLD} state_t;

   state_t         state_q;
   logic [4:0]     cnt_q;
   logic [255:0]   keyShadow_q;
   logic [63:0]    ctShadow_q;
   logic [255:0]   key_q;
   logic [63:0]    ct_q;
   logic           keyLoaded_q;
   logic           blkValid_q;
   logic           err_q;

   logic           inReady;
   logic           accept;
   logic [255:0]   keyShadow_d;
   logic [63:0]    ctShadow_d;

   assign inReady     = (state_q != HOLD);
   assign accept      = bus.in_valid && inReady;
   assign keyShadow_d = {keyShadow_q[247:0], bus.in_data};
   assign ctShadow_d  = {ctShadow_q[55:0], bus.in_data};

   // Shadows fill byte by byte; visible outputs only move on the final byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 5'd0;
         keyShadow_q <= '0;
         ctShadow_q  <= '0;
         key_q       <= '0;
         ct_q        <= '0;
         keyLoaded_q <= 1'b0;
         blkValid_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (bus.in_data == CMD_KEY) begin
                     state_q <= KEY;
                     cnt_q   <= 5'd0;
                  end else if (bus.in_data == CMD_DATA && keyLoaded_q) begin
                     state_q <= DATA;
                     cnt_q   <= 5'd0;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            KEY: begin
               if (accept) begin
                  keyShadow_q <= keyShadow_d;
                  if (cnt_q == 5'd31) begin
                     key_q       <= keyShadow_d;
                     keyLoaded_q <= 1'b1;
                     state_q     <= IDLE;
                     cnt_q       <= 5'd0;
                  end else begin
                     cnt_q <= cnt_q + 5'd1;
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  ctShadow_q <= ctShadow_d;
                  if (cnt_q == 5'd7) begin
                     ct_q       <= ctShadow_d;
                     blkValid_q <= 1'b1;
                     state_q    <= HOLD;
                     cnt_q      <= 5'd0;
                  end else begin
                     cnt_q <= cnt_q + 5'd1;
                  end
               end
            end
            HOLD: begin
               if (bus.blk_ready) begin
                  blkValid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready   = inReady;
   assign bus.key        = key_q;
   assign bus.ciphertext = ct_q;
   assign bus.key_loaded = keyLoaded_q;
   assign bus.blk_valid  = blkValid_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_gost_block_loader.sv
// Scoreboard bench for gost_block_loader: a frame-level model queues expected
// key/block/error events, an independent monitor matches them against the DUT.
module tb_gost_block_loader;

   localparam int EV_ERR = 0;
   localparam int EV_KEY = 1;
   localparam int EV_BLK = 2;

   typedef struct {
      int           kind;
      logic [255:0] val;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   gost_block_loader_if bus();

   gost_block_loader dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   ev_t expQ[$];
   int readyMode = 0;

   bit          mdlLoaded = 1'b0;
   int          mdlNeed = 0;
   bit          mdlIsKey = 1'b0;
   logic [7:0]  frame[$];

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Frame-level protocol model: a command opens a frame of fixed length,
   // the finished frame is laid out first byte most significant.
   function automatic void modelByte(input logic [7:0] b);
      ev_t e;
      logic [255:0] v;
      if (mdlNeed > 0) begin
         frame.push_back(b);
         mdlNeed--;
         if (mdlNeed == 0) begin
            v = '0;
            if (mdlIsKey) begin
               for (int i = 0; i < 32; i++) v[255-8*i -: 8] = frame[i];
               e.kind = EV_KEY;
               mdlLoaded = 1'b1;
            end else begin
               for (int i = 0; i < 8; i++) v[63-8*i -: 8] = frame[i];
               e.kind = EV_BLK;
            end
            e.val = v;
            expQ.push_back(e);
         end
      end else if (b == 8'h4B) begin
         mdlIsKey = 1'b1;
         mdlNeed = 32;
         frame.delete();
      end else if (b == 8'h43 && mdlLoaded) begin
         mdlIsKey = 1'b0;
         mdlNeed = 8;
         frame.delete();
      end else begin
         e.kind = EV_ERR;
         e.val = '0;
         expQ.push_back(e);
      end
   endfunction

   task automatic applyStimulus(input logic [7:0] b, input bit gap);
      int waitCnt;
      waitCnt = 0;
      if (gap) begin
         bus.in_valid = 1'b0;
         @(posedge clk); #1;
      end
      bus.in_data = b;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && waitCnt < 300) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      if (!bus.in_ready) begin
         checkOutput("in_ready timeout", 256'd0, 256'd1);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      modelByte(b);
      bus.in_valid = 1'b0;
   endtask

   // pattern: 0 sequential from base, 1 random, 2 random with command values embedded
   task automatic sendFrame(input logic [7:0] cmd, input int n, input int pattern,
                            input logic [7:0] base, input int gapMode);
      logic [7:0] b;
      bit gap;
      applyStimulus(cmd, 1'b0);
      for (int i = 0; i < n; i++) begin
         if (pattern == 0) b = base + 8'(i);
         else b = 8'($urandom_range(255));
         if (pattern == 2 && i == 3) b = 8'h43;
         if (pattern == 2 && i == 10) b = 8'h4B;
         gap = (gapMode == 1) ? 1'b1 : (gapMode == 2) ? ($urandom_range(2) == 0) : 1'b0;
         applyStimulus(b, gap);
      end
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((expQ.size() != 0 || bus.blk_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput("queue drained", 256'(expQ.size()), 256'd0);
   endtask

   task automatic doReset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      mdlLoaded = 1'b0;
      mdlNeed = 0;
      frame.delete();
      @(negedge clk);
      checkOutput("reset key", bus.key, 256'd0);
      checkOutput("reset ciphertext", 256'(bus.ciphertext), 256'd0);
      checkOutput("reset key_loaded", 256'(bus.key_loaded), 256'd0);
      checkOutput("reset blk_valid", 256'(bus.blk_valid), 256'd0);
      checkOutput("reset err", 256'(bus.err), 256'd0);
      checkOutput("reset in_ready", 256'(bus.in_ready), 256'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Downstream consumer: stalled, always ready, or randomly ready.
   always @(posedge clk) begin
      #1;
      case (readyMode)
         0:       bus.blk_ready = 1'b0;
         2:       bus.blk_ready = 1'b1;
         default: bus.blk_ready = ($urandom_range(1) == 1);
      endcase
   end

   logic [255:0] monKey;
   logic [63:0]  monCt;
   bit           monLoaded;
   bit           monPrevBlk;
   bit           monExpectDrop;

   task automatic popExpect(input int kind, input logic [255:0] act, input string name);
      ev_t e;
      if (expQ.size() == 0) begin
         checkOutput({name, " unexpected"}, 256'd1, 256'd0);
         return;
      end
      e = expQ.pop_front();
      checkOutput({name, " kind"}, 256'(kind), 256'(e.kind));
      checkOutput(name, act, e.val);
   endtask

   // Monitor samples on the falling edge, independent of the driver.
   always @(negedge clk) begin
      if (!rst_n) begin
         monKey = '0;
         monCt = '0;
         monLoaded = 1'b0;
         monPrevBlk = 1'b0;
         monExpectDrop = 1'b0;
      end else begin
         if (bus.err) popExpect(EV_ERR, 256'd0, "err pulse");
         if (bus.key !== monKey) begin
            popExpect(EV_KEY, bus.key, "key");
            monKey = bus.key;
            monLoaded = 1'b1;
         end
         checkOutput("key_loaded", 256'(bus.key_loaded), 256'(monLoaded));
         if (bus.blk_valid && !monPrevBlk) begin
            popExpect(EV_BLK, 256'(bus.ciphertext), "ciphertext");
         end else if (monPrevBlk) begin
            if (monExpectDrop) begin
               checkOutput("blk_valid drop", 256'(bus.blk_valid), 256'd0);
            end else begin
               checkOutput("blk_valid hold", 256'(bus.blk_valid), 256'd1);
               checkOutput("ciphertext hold", 256'(bus.ciphertext), 256'(monCt));
            end
         end
         checkOutput("in_ready", 256'(bus.in_ready), 256'(!bus.blk_valid));
         monExpectDrop = bus.blk_valid && bus.blk_ready;
         monPrevBlk = bus.blk_valid;
         monCt = bus.ciphertext;
      end
   end

   initial begin
      int r;
      bus.in_data = 8'h00;
      bus.in_valid = 1'b0;
      bus.blk_ready = 1'b0;
      readyMode = 0;
      doReset();

      sendFrame(8'h4B, 32, 0, 8'h00, 0);
      waitDrain();

      sendFrame(8'h43, 8, 0, 8'h01, 0);
      repeat (5) @(negedge clk);
      readyMode = 2;
      waitDrain();
      readyMode = 1;

      doReset();
      applyStimulus(8'h43, 1'b0);
      applyStimulus(8'h55, 1'b0);
      sendFrame(8'h4B, 32, 0, 8'h00, 0);
      sendFrame(8'h4B, 32, 2, 8'h00, 1);
      sendFrame(8'h43, 8, 1, 8'h00, 2);
      waitDrain();

      applyStimulus(8'h43, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(8'(8'h60 + i), 1'b0);
      doReset();
      sendFrame(8'h43, 8, 0, 8'hAA, 0);
      sendFrame(8'h4B, 32, 1, 8'h00, 2);
      sendFrame(8'h43, 8, 1, 8'h00, 0);
      waitDrain();

      for (int k = 0; k < 25; k++) begin
         r = $urandom_range(9);
         if (r < 3) sendFrame(8'h4B, 32, 1, 8'h00, 2);
         else if (r < 8) sendFrame(8'h43, 8, 1, 8'h00, 2);
         else applyStimulus(8'($urandom_range(255)), 1'b0);
      end
      for (int k = 0; k < 40 && mdlNeed > 0; k++) applyStimulus(8'($urandom_range(255)), 1'b0);
      checkOutput("model idle", 256'(mdlNeed), 256'd0);
      waitDrain();
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
